sys_tx_ctrl: RTL
================

Name: sys_tx_ctrl

Overview:
- Parametrised transmit-side controller between the system control domain and the UART transmitter.
- Buffers one register-read byte and one multi-frame ALU result, arbitrates between them, and serialises each into DATA_WIDTH frames.
- Handshakes every frame with the UART TX using the valid/busy pair.
- Successor to the fixed two-frame ALU sender. Adds:
  - a generic frame count
  - selectable byte order and source priority
  - simultaneous-arrival buffering
  - overflow reporting

Parameters:
DATA_WIDTH, 8, width of one UART frame payload
ALU_FRAMES, 2, number of DATA_WIDTH frames per ALU result (>=1); ALU width = DATA_WIDTH*ALU_FRAMES
MSB_FIRST, 0, 0: ALU result sent least-significant frame first; 1: most-significant first
REG_PRIORITY, 1, 1: pending register byte wins arbitration over pending ALU result; 0: ALU wins

Ports:
CLK  input  1  system clock
RST  input  1  synchronous active-high reset
Rd_D  input  DATA_WIDTH  register-file read data
Rd_D_VLD  input  1  Rd_D valid, single-cycle pulse
ALU_OUT  input  DATA_WIDTH*ALU_FRAMES  ALU result
OUT_VLD  input  1  ALU_OUT valid, single-cycle pulse
busy  input  1  UART TX busy
TX_P_Data  output  DATA_WIDTH  frame payload to UART TX, registered
TX_D_VLD  output  1  frame valid to UART TX, registered
clk_div_en  output  1  UART clock-divider enable
tx_active  output  1  high while a message (any frame) is in progress
ovf  output  1  sticky: a source arrived while its buffer was still occupied

Behaviour:
- Clock and reset:
  - Single clock CLK. Reset RST is synchronous and active-high: it is sampled only on the rising CLK edge.
  - Reset values: TX_P_Data=0, TX_D_VLD=0, clk_div_en=0, tx_active=0, ovf=0. Both buffers are empty, the state is IDLE and the frame counter is 0.
  - clk_div_en goes to 1 on the first cycle after reset deasserts and stays 1.
- Buffers:
  - reg_buf (DATA_WIDTH) with flag reg_pend; alu_buf (full ALU width) with flag alu_pend.
  - Rd_D_VLD with reg_pend=0 captures Rd_D and sets reg_pend. Same rule for OUT_VLD with alu_buf.
  - Arrival while the flag is already 1: the data is dropped, the buffer is unchanged and ovf is set. ovf is cleared only by reset.
  - A flag clears on the cycle its message is selected (LOAD). The buffer may then refill during that transmission.
- States:
  - IDLE: if any flag is set, go to LOAD. Arbitration follows REG_PRIORITY when both are set, including flags set in the same cycle.
  - LOAD:
    - Latch the selected source into the shift register and its frame count (1 for reg, ALU_FRAMES for ALU).
    - Drive TX_P_Data with the first frame: low slice, or high slice if MSB_FIRST=1.
    - Set TX_D_VLD=1 and tx_active=1, then go to SEND.
  - SEND: hold TX_D_VLD=1 and TX_P_Data stable until busy=1 is sampled. Then drop TX_D_VLD to 0 and go to WAIT.
  - WAIT: wait for busy=0.
    - If frames remain: present the next slice, set TX_D_VLD=1, decrement the count and go to SEND.
    - Otherwise: tx_active=0 and go to IDLE.
- Latency and throughput:
  - First TX_D_VLD rises 2 cycles after the capturing Rd_D_VLD/OUT_VLD edge from IDLE (IDLE -> LOAD -> SEND).
  - Back-to-back messages: IDLE is entered for at least 1 cycle between messages.
  - Frames of one message are never interleaved with another source.
- Other rules:
  - busy already high in IDLE/LOAD: LOAD proceeds, and SEND exits on the first sampled busy=1.
  - Reset mid-message: the message is abandoned and both buffers are cleared. TX_D_VLD=0 on the next cycle.
  - ALU_FRAMES=1 degenerates to single-frame sends for both sources.
  - All outputs are registered, with no combinational path from input to output.

Decomposition:
- Shared package sys_tx_pkg:
  - state encoding enum (IDLE, LOAD, SEND, WAIT)
  - frame-count width function clog2(ALU_FRAMES+1)
  - source-select constants (SRC_REG, SRC_ALU)
- One natural sub-module: sys_tx_frame_sel. It is the parametrised shift register with frame counter, handling load, slice select by MSB_FIRST, and advance.

Test Plan:
1. Reg read: Rd_D=0xA5 pulse in IDLE, busy pulses 3 cycles after TX_D_VLD rise -> one frame 0xA5; TX_D_VLD high until busy sampled; tx_active falls after busy falls.
2. ALU, ALU_FRAMES=2, MSB_FIRST=0: ALU_OUT=0x1234 -> frames 0x34 then 0x12, each with its own valid/busy handshake. Repeat with MSB_FIRST=1 -> 0x12 then 0x34.
3. Simultaneous Rd_D_VLD(0x5A) and OUT_VLD(0xBEEF), REG_PRIORITY=1 -> 0x5A, then 0xEF, 0xBE; ovf=0. With REG_PRIORITY=0 -> 0xEF, 0xBE, 0x5A.
4. Overflow: two OUT_VLD pulses (0x1111, then 0x2222) while alu_pend=1 and the reg message is transmitting -> only 0x1111 frames sent; ovf=1 sticky.
5. ALU_FRAMES=4, ALU_OUT=0xDEADBEEF -> EF, BE, AD, DE, in order, 4 handshakes, no gaps with TX_D_VLD=1 during busy.
6. RST asserted during the second frame of a 2-frame send -> next cycle TX_D_VLD=0, tx_active=0, ovf=0, clk_div_en=0; after release no residual frames are sent.

Source files
------------

// File: rtl/sys_tx_pkg.sv
// Shared types and constants for the system-to-UART transmit controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sys_tx_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } state_t;

  // Message source selectors
  localparam logic SRC_REG = 1'b0;
  localparam logic SRC_ALU = 1'b1;

  // Width of a counter able to hold 0..frames
  function automatic int cnt_width(input int frames);
    return $clog2(frames + 1);
  endfunction

endpackage

// File: rtl/sys_tx_frame_sel.sv
// Shift register and frame counter that slices one message into DATA_WIDTH frames.
// Latency: first_frame is combinational from the load source; next_frame is registered state.
// Backpressure: advances only when the controller pulses advance; otherwise holds.
module sys_tx_frame_sel
  import sys_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_FRAMES = 2,
  parameter int MSB_FIRST  = 0
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               load,
  input  logic                               load_src,
  input  logic [DATA_WIDTH-1:0]              reg_data,
  input  logic [DATA_WIDTH*ALU_FRAMES-1:0]   alu_data,
  input  logic                               advance,
  output logic [DATA_WIDTH-1:0]              first_frame,
  output logic [DATA_WIDTH-1:0]              next_frame,
  output logic                               more
);

  localparam int AW = DATA_WIDTH * ALU_FRAMES;
  localparam int CW = cnt_width(ALU_FRAMES);

  logic [AW-1:0] shreg;
  logic [AW-1:0] load_vec;
  // Frames still to send after the one currently on the wire
  logic [CW-1:0] rem;

  // Frame that goes out next, at the end chosen by MSB_FIRST
  function automatic logic [DATA_WIDTH-1:0] head(input logic [AW-1:0] v);
    if (MSB_FIRST != 0) return v[AW-1 -: DATA_WIDTH];
    else                return v[DATA_WIDTH-1:0];
  endfunction

  // Remove the head frame so the following one moves into its place
  function automatic logic [AW-1:0] drop_head(input logic [AW-1:0] v);
    if (MSB_FIRST != 0) return v << DATA_WIDTH;
    else                return v >> DATA_WIDTH;
  endfunction

  // Align a register byte with the head slot so both sources share one path
  always_comb begin
    load_vec = '0;
    if (load_src == SRC_ALU)  load_vec = alu_data;
    else if (MSB_FIRST != 0)  load_vec[AW-1 -: DATA_WIDTH] = reg_data;
    else                      load_vec[DATA_WIDTH-1:0] = reg_data;
  end

  // The first frame leaves directly on load, so the register keeps only what follows it
  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg <= '0;
      rem   <= '0;
    end else if (load) begin
      shreg <= drop_head(load_vec);
      rem   <= (load_src == SRC_ALU) ? CW'(ALU_FRAMES - 1) : '0;
    end else if (advance && (rem != '0)) begin
      shreg <= drop_head(shreg);
      rem   <= rem - CW'(1);
    end
  end

  assign first_frame = head(load_vec);
  assign next_frame  = head(shreg);
  assign more        = (rem != '0);

endmodule

// File: rtl/sys_tx_ctrl.sv
// Buffers a register byte and an ALU result, arbitrates, and feeds them frame by frame to the UART TX.
// Latency: first TX_D_VLD two cycles after the capturing valid edge (IDLE -> LOAD -> SEND).
// Backpressure: each frame held valid until busy is sampled high; next frame waits for busy low.
module sys_tx_ctrl
  import sys_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ALU_FRAMES   = 2,
  parameter int MSB_FIRST    = 0,
  parameter int REG_PRIORITY = 1
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [DATA_WIDTH-1:0]             Rd_D,
  input  logic                              Rd_D_VLD,
  input  logic [DATA_WIDTH*ALU_FRAMES-1:0]  ALU_OUT,
  input  logic                              OUT_VLD,
  input  logic                              busy,
  output logic [DATA_WIDTH-1:0]             TX_P_Data,
  output logic                              TX_D_VLD,
  output logic                              clk_div_en,
  output logic                              tx_active,
  output logic                              ovf
);

  localparam int AW = DATA_WIDTH * ALU_FRAMES;

  state_t                state;
  logic [DATA_WIDTH-1:0] reg_buf;
  logic                  reg_pend;
  logic [AW-1:0]         alu_buf;
  logic                  alu_pend;
  logic                  sel_src;
  logic                  ld;
  logic                  adv;
  logic                  clr_reg;
  logic                  clr_alu;
  logic [DATA_WIDTH-1:0] first_frame;
  logic [DATA_WIDTH-1:0] next_frame;
  logic                  more;

  // Pick the source to load; only meaningful in LOAD, where at least one flag is set
  always_comb begin
    if (REG_PRIORITY != 0) sel_src = reg_pend ? SRC_REG : SRC_ALU;
    else                   sel_src = alu_pend ? SRC_ALU : SRC_REG;
  end

  assign ld      = (state == LOAD);
  assign adv     = (state == WAIT) && !busy && more;
  assign clr_reg = ld && (sel_src == SRC_REG);
  assign clr_alu = ld && (sel_src == SRC_ALU);

  // Single-entry buffers; an arrival while the flag is still up is dropped and flagged
  always_ff @(posedge CLK) begin
    if (RST) begin
      reg_buf  <= '0;
      reg_pend <= 1'b0;
      alu_buf  <= '0;
      alu_pend <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (clr_reg) begin
        reg_pend <= 1'b0;
      end else if (Rd_D_VLD && !reg_pend) begin
        reg_pend <= 1'b1;
        reg_buf  <= Rd_D;
      end
      if (clr_alu) begin
        alu_pend <= 1'b0;
      end else if (OUT_VLD && !alu_pend) begin
        alu_pend <= 1'b1;
        alu_buf  <= ALU_OUT;
      end
      if ((Rd_D_VLD && reg_pend) || (OUT_VLD && alu_pend)) ovf <= 1'b1;
    end
  end

  // Message sequencing with registered UART-side outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      TX_P_Data  <= '0;
      TX_D_VLD   <= 1'b0;
      tx_active  <= 1'b0;
      clk_div_en <= 1'b0;
    end else begin
      clk_div_en <= 1'b1;
      case (state)
        IDLE: begin
          if (reg_pend || alu_pend) state <= LOAD;
        end
        LOAD: begin
          TX_P_Data <= first_frame;
          TX_D_VLD  <= 1'b1;
          tx_active <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (busy) begin
            TX_D_VLD <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!busy) begin
            if (more) begin
              TX_P_Data <= next_frame;
              TX_D_VLD  <= 1'b1;
              state     <= SEND;
            end else begin
              tx_active <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sys_tx_frame_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .ALU_FRAMES (ALU_FRAMES),
    .MSB_FIRST  (MSB_FIRST)
  ) u_frame_sel (
    .CLK         (CLK),
    .RST         (RST),
    .load        (ld),
    .load_src    (sel_src),
    .reg_data    (reg_buf),
    .alu_data    (alu_buf),
    .advance     (adv),
    .first_frame (first_frame),
    .next_frame  (next_frame),
    .more        (more)
  );

endmodule
